// File: rtl/clas_pkg.sv
// clas_pkg: shared constants and carry look-ahead helpers for clas_pipe_nbit.
package clas_pkg;

    localparam int unsigned GRP_W     = 4;
    localparam int unsigned SAT_MAX_W = 64;

    // Returns the carry out of each bit of a 4-bit group: c[i] is the carry into bit i+1.
    function automatic logic [GRP_W-1:0] clas_grp_carry(
        input logic [GRP_W-1:0] g,
        input logic [GRP_W-1:0] p,
        input logic             cin
    );
        logic [GRP_W-1:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] SAT_MAX(input int unsigned w);
        logic [SAT_MAX_W-1:0] one;
        one = SAT_MAX_W'(1);
        return (one << (w - 1)) - one;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] SAT_MIN(input int unsigned w);
        logic [SAT_MAX_W-1:0] one;
        one = SAT_MAX_W'(1);
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/clas_grp4.sv
// clas_grp4: combinational 4-bit carry look-ahead group; c3 is the carry into bit 3.
module clas_grp4
    import clas_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] sum,
    output logic             cout,
    output logic             c3
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] c;

    assign g    = a & b;
    assign p    = a | b;
    assign c    = clas_grp_carry(g, p, cin);
    assign sum  = a ^ b ^ {c[GRP_W-2:0], cin};
    assign cout = c[GRP_W-1];
    assign c3   = c[GRP_W-2];

endmodule

// File: rtl/clas_pipe_nbit.sv
// clas_pipe_nbit: pipelined carry look-ahead adder/subtractor, one 4-bit group per stage.
// Optional signed saturation is compiled in when CLAS_SAT_EN is defined.
module clas_pipe_nbit
    import clas_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLAS_SAT_EN
    input  logic             sat_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NGRP = WIDTH / GRP_W;
    localparam int unsigned TOP  = NGRP - 1;

    if ((WIDTH % GRP_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("clas_pipe_nbit: WIDTH must be a multiple of 4 and at least 8");
    end

    // Index k holds the inputs of group stage k; index 0 is the capture register at the port.
    logic             v_q   [NGRP];
    logic [WIDTH-1:0] a_q   [NGRP];
    logic [WIDTH-1:0] b_q   [NGRP];
    logic             c_q   [NGRP];
    logic [WIDTH-1:0] s_q   [NGRP];
`ifdef CLAS_SAT_EN
    logic             sat_q [NGRP];
`endif

    logic [GRP_W-1:0] g_sum  [NGRP];
    logic             g_cout [NGRP];
    logic             g_c3   [NGRP];
    logic [WIDTH-1:0] nxt_s  [NGRP];

    logic             adv;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_n;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        clas_grp4 u_grp (
            .a    (a_q[k][GRP_W*k +: GRP_W]),
            .b    (b_q[k][GRP_W*k +: GRP_W]),
            .cin  (c_q[k]),
            .sum  (g_sum[k]),
            .cout (g_cout[k]),
            .c3   (g_c3[k])
        );
        // Partial sum is zero above group k, so OR-ing in the new nibble places it.
        assign nxt_s[k] = s_q[k] | (WIDTH'(g_sum[k]) << (GRP_W * k));
    end

    assign raw_ovf = g_c3[TOP] ^ g_cout[TOP];

`ifdef CLAS_SAT_EN
    always_comb begin
        res_n = nxt_s[TOP];
        if (sat_q[TOP] && raw_ovf) begin
            res_n = (~a_q[TOP][WIDTH-1] & ~b_q[TOP][WIDTH-1]) ? WIDTH'(SAT_MAX(WIDTH))
                                                            : WIDTH'(SAT_MIN(WIDTH));
        end
    end
`else
    assign res_n = nxt_s[TOP];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NGRP; i++) begin
                v_q[i]   <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                c_q[i]   <= 1'b0;
                s_q[i]   <= '0;
`ifdef CLAS_SAT_EN
                sat_q[i] <= 1'b0;
`endif
            end
            out_valid <= 1'b0;
            result    <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (adv) begin
            v_q[0]   <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= b ^ {WIDTH{sel}};
            c_q[0]   <= c_in;
            s_q[0]   <= '0;
`ifdef CLAS_SAT_EN
            sat_q[0] <= sat_en;
`endif
            for (int unsigned i = 1; i < NGRP; i++) begin
                v_q[i]   <= v_q[i-1];
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
                c_q[i]   <= g_cout[i-1];
                s_q[i]   <= nxt_s[i-1];
`ifdef CLAS_SAT_EN
                sat_q[i] <= sat_q[i-1];
`endif
            end
            out_valid <= v_q[TOP];
            // Bubbles leave the last result and flags untouched.
            if (v_q[TOP]) begin
                result <= res_n;
                c_out  <= g_cout[TOP];
                ovf    <= raw_ovf;
                zero   <= (res_n == '0);
                neg    <= res_n[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_clas_pipe_nbit.sv
// tb_clas_pipe_nbit: randomized and directed checks of clas_pipe_nbit against an arithmetic reference.
// Saturation expectations follow CLAS_SAT_EN when it is defined.
module tb_clas_pipe_nbit;

    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel       = 1'b0;
    logic        c_in      = 1'b0;
    logic        sat_en    = 1'b0;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        c_out;
    logic        ovf;
    logic        zero;
    logic        neg;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        held       = 1'b0;
    logic [15:0] held_res   = '0;
    logic [3:0]  held_flags = '0;
    logic        stop       = 1'b0;

    always #5 clk = ~clk;

    clas_pipe_nbit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CLAS_SAT_EN
        .sat_en    (sat_en),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a 17-bit sum; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic ci, input logic st);
        exp_t        e;
        logic [15:0] yb;
        logic [16:0] full;
        yb   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {16'd0, ci};
        e.res = full[15:0];
        e.c   = full[16];
        e.o   = (x[15] == yb[15]) && (full[15] != x[15]);
`ifdef CLAS_SAT_EN
        if (st && e.o) e.res = x[15] ? 16'h8000 : 16'h7FFF;
`else
        if (st && 1'b0) e.res = '0;
`endif
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_result", result, held_res);
                check("hold_flags", {c_out, ovf, zero, neg}, held_flags);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else if (out_ready) begin
                    mon_e = exp_q.pop_front();
                    check("result", result, mon_e.res);
                    check("flags", {c_out, ovf, zero, neg}, {mon_e.c, mon_e.o, mon_e.z, mon_e.n});
                end
            end
            held       = out_valid && !out_ready;
            held_res   = result;
            held_flags = {c_out, ovf, zero, neg};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sel, c_in, sat_en));
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic ci, input logic st);
        int unsigned n;
        logic        rdy;
        n        = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sel      = s;
        c_in     = ci;
        sat_en   = st;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        check("accept", rdy, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int unsigned cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic ci, input logic st,
                            input logic [15:0] er, input logic [3:0] ef);
        int unsigned cyc;
        send(x, y, s, ci, st);
        wait_out(cyc);
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_result"}, result, er);
        check({tag, "_flags"}, {c_out, ovf, zero, neg}, ef);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 16'h0000);
        check("rst_flags", {c_out, ovf, zero, neg}, 4'b0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // flags are {c_out, ovf, zero, neg}
        directed("add",  16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 4'b0000);
        directed("subz", 16'h00A5, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b1010);
        directed("subn", 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, 16'hFFFF, 4'b0001);
`ifdef CLAS_SAT_EN
        directed("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 4'b0100);
`else
        directed("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 4'b0101);
`endif
        directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1010);

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                #1;
                check("bp_in_ready_low", in_ready, 0);
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", out_valid, 0);
        end
        directed("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b0, 16'h1011, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
